// File: rtl/ascon_init_seq_pkg.sv
// Shared types and constants for the Ascon-128 initialization sequencer.
package ascon_init_seq_pkg;

  // Five 64-bit state words; index 0 is x0.
  typedef logic [4:0][63:0] state_t;

  localparam logic [63:0] ASCON128_IV = 64'h80400c0600000000;

  // Width of the watchdog counter.
  localparam int WD_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_FINAL,
    ST_DONE,
    ST_DRAIN
  } fsm_t;

  // Assemble IV || K || N into the five state words.
  function automatic state_t init_state(input logic [63:0]  iv,
                                        input logic [127:0] key,
                                        input logic [127:0] nonce);
    state_t s;
    s[0] = iv;
    s[1] = key[127:64];
    s[2] = key[63:0];
    s[3] = nonce[127:64];
    s[4] = nonce[63:0];
    return s;
  endfunction

  // Closing key XOR that finishes the initialization phase.
  function automatic state_t final_key_xor(input state_t s, input logic [127:0] key);
    state_t r;
    r    = s;
    r[3] = s[3] ^ key[127:64];
    r[4] = s[4] ^ key[63:0];
    return r;
  endfunction

endpackage

// File: rtl/ascon_init_seq.sv
// Ascon-128 initialization sequencer: accepts key/nonce, launches the init
// permutation engine, captures its state stream, applies the closing key XOR
// and hands the 320-bit state to the consumer. Includes abort and watchdog.
module ascon_init_seq
  import ascon_init_seq_pkg::*;
#(
  parameter logic [63:0] IV      = ASCON128_IV,
  parameter int          TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic         abort_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output state_t       state_o,
  output logic         error_o,
  output logic         busy_o,
  output logic         perm_start_o,
  output state_t       perm_state_o,
  input  state_t       perm_state_i,
  input  logic         perm_update_i,
  input  logic         perm_done_i
);

  // Counter value on the last WAIT/DRAIN cycle that is still within budget.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  fsm_t            fsm_q, fsm_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    nonce_q, nonce_d;
  state_t          work_q, work_d;
  state_t          perm_q, perm_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic            start_q, start_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_LAST);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    fsm_d   = fsm_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    work_d  = work_q;
    perm_d  = perm_q;
    wd_d    = wd_q;
    error_d = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          key_d   = key_i;
          nonce_d = nonce_i;
          fsm_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort_i) begin
          fsm_d = ST_IDLE;
        end else begin
          work_d = init_state(IV, key_q, nonce_q);
          perm_d = init_state(IV, key_q, nonce_q);
          fsm_d  = ST_START;
        end
      end
      ST_START: begin
        wd_d  = '0;
        fsm_d = abort_i ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (perm_update_i) work_d = perm_state_i;
        if (perm_done_i) begin
          // An abort coinciding with completion needs no drain.
          fsm_d = abort_i ? ST_IDLE : ST_FINAL;
        end else if (wd_expired) begin
          error_d = 1'b1;
          fsm_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
          if (abort_i) fsm_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The engine cannot be stopped; wait for it to finish, still guarded.
        if (perm_done_i) begin
          fsm_d = ST_IDLE;
        end else if (wd_expired) begin
          error_d = 1'b1;
          fsm_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_FINAL: begin
        if (abort_i) begin
          fsm_d = ST_IDLE;
        end else begin
          work_d = final_key_xor(work_q, key_q);
          fsm_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // Ready wins over abort: both leave DONE, the transfer counts.
        if (out_ready_i || abort_i) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase

    cmd_ready_d = (fsm_d == ST_IDLE);
    busy_d      = (fsm_d != ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
    start_d     = (fsm_d == ST_START);
  end

  // State, datapath and output registers; everything clears on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q       <= ST_IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      work_q      <= '0;
      perm_q      <= '0;
      wd_q        <= '0;
      error_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      work_q      <= work_d;
      perm_q      <= perm_d;
      wd_q        <= wd_d;
      error_q     <= error_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign busy_o       = busy_q;
  assign out_valid_o  = out_valid_q;
  assign error_o      = error_q;
  assign state_o      = work_q;
  assign perm_state_o = perm_q;
  // An abort in START must keep the engine from ever being launched.
  assign perm_start_o = start_q & ~abort_i;

endmodule

// File: doc/ascon_init_seq.md
# ascon_init_seq

Sequencer for the Ascon-128 initialization phase. It accepts a key/nonce command over a valid/ready handshake and assembles the initial state IV‖K‖N. It then launches the 12-round init permutation engine and captures that engine's state stream, applies the final key XOR, and presents the resulting 320-bit state on a valid/ready output. It sits between the host/register front-end and the permutation engine, which it owns exclusively. It also provides abort and watchdog handling.

## Interface
- IV, default 64'h80400c0600000000: Ascon-128 initialization vector, loaded into word x0.
- TIMEOUT, default 16: maximum number of cycles allowed from perm_start_o to perm_done_i.
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- key_i  in  128  key K; bits [127:64] are the high word
- nonce_i  in  128  nonce N; bits [127:64] are the high word
- abort_i  in  1  synchronous abort request
- out_valid_o  out  1  result state valid
- out_ready_i  in  1  consumer takes the result
- state_o  out  state_t  result state (5×64)
- error_o  out  1  one-cycle pulse on watchdog expiry
- busy_o  out  1  high whenever fsm != IDLE
- perm_start_o  out  1  start pulse to the permutation engine
- perm_state_o  out  state_t  initial state driven to the engine
- perm_state_i  in  state_t  engine state output
- perm_update_i  in  1  engine state output is live (engine busy)
- perm_done_i  in  1  engine finished pulse

## Operation
- FSM states: IDLE, LOAD, START, WAIT, FINAL, DONE, DRAIN.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch key_i and nonce_i, then go to LOAD.
- LOAD: form the initial state into the work register: x0 = IV, x1 = K[127:64], x2 = K[63:0], x3 = N[127:64], x4 = N[63:0]. Then go to START.
- START:
  - perm_start_o = 1 for exactly this one cycle.
  - Clear the watchdog counter, then go to WAIT.
- perm_state_o is driven from a dedicated register loaded in LOAD. It is held constant from LOAD until the FSM returns to IDLE.
- WAIT:
  - Whenever perm_update_i = 1, capture perm_state_i into the work register.
  - On perm_done_i, go to FINAL. The work register then holds the output of round 12.
- FINAL: x3 ^= K[127:64], x4 ^= K[63:0]. Then go to DONE.
- DONE:
  - out_valid_o = 1 and state_o = work register.
  - Go to IDLE on out_ready_i. The output stays stable while stalled.
- Watchdog:
  - A 5-bit counter increments every WAIT cycle.
  - If the count reaches TIMEOUT before perm_done_i: pulse error_o for one cycle, go to IDLE, produce no output.
- Abort:
  - abort_i in LOAD or START: go straight to IDLE. In START, perm_start_o is suppressed that cycle.
  - abort_i in WAIT: go to DRAIN. The engine cannot be stopped, so DRAIN waits for perm_done_i (watchdog still active), then goes to IDLE.
  - abort_i in FINAL or DONE: go to IDLE and drop out_valid_o.
  - abort_i is ignored in IDLE.
- Simultaneous events:
  - abort_i with perm_done_i in WAIT: go to IDLE directly.
  - abort_i with out_ready_i in DONE: counts as a completed transfer.
  - cmd_valid_i is never accepted outside IDLE.
- Reset values: all outputs 0, FSM = IDLE, all registers 0. A reset mid-operation returns the block to IDLE immediately. The engine shares rst_n_i and resets with it.

## Timing
- Cycle 0: command accepted.
- Cycle 1: LOAD.
- Cycle 2: START (perm_start_o = 1).
- Cycles 3–14: engine busy, perm_update_i = 1 for 12 cycles.
- Cycle 15: perm_done_i.
- Cycle 16: FINAL.
- Cycle 17: out_valid_o first high. Command-to-result latency is 17 cycles.
- Back-to-back operation: the next command can be accepted in the cycle after the out_valid & out_ready transfer.
- Minimum command spacing is 18 cycles.
- The watchdog measures from the first WAIT cycle. The nominal wait is 13 cycles, below the TIMEOUT default of 16.

## Structure
- Shared package (existing ascon package):
  - state_t (5×64 packed array, word 0 = x0)
  - ASCON128_IV constant
  - fsm enum for this block
- No sub-module: a single module with the FSM, work register, key register and watchdog counter.
- Benches instantiate it with the existing init permutation block, or with a behavioural engine stub with configurable latency.

## Test plan
- Reference vector: K = 000102…0F, N = 000102…0F, with the real engine. After the key XOR, state_o must equal the Ascon-128 reference post-init state; out_valid_o must rise at cycle 17.
- Back-pressure: hold out_ready_i = 0 for 10 cycles. state_o must stay stable, cmd_ready_o = 0, and the second command must be accepted the cycle after the transfer.
- Abort in WAIT at cycle 8: busy_o stays high until perm_done_i (cycle 15), the block returns to IDLE at cycle 16, out_valid_o never rises, and a new command then completes correctly.
- Watchdog: the stub never asserts perm_done_i. error_o pulses 16 cycles after the first WAIT cycle, the block returns to IDLE, and no output is produced.
- Abort and done in the same cycle in WAIT: next state is IDLE with no error_o and no out_valid_o. Abort in START: perm_start_o is never asserted.
- Reset asserted at cycle 10 mid-permutation: all outputs are 0 immediately, and the first command after reset release yields the correct reference state.
